f2_equiv_sweeper: RTL and testbench

//  Sequential stimulus driver and response checker for the f2 logic block (inputs b,d,g,f,e;

---
 rtl/f2_equiv_sweeper_if.sv | 25 ++
 rtl/f2_equiv_sweeper.sv | 133 +++++++++++++
 tb/tb_f2_equiv_sweeper.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/f2_equiv_sweeper_if.sv
// Handshake/result bundle between the f2 sweeper and its controller plus the block under test.
// slave = the sweeper itself; master = the side that issues start and returns the f2 responses.
interface f2_equiv_sweeper_if;
    logic       start;
    logic [4:0] pat_o;
    logic       f2_i;
    logic       f2_min_i;
    logic       f2_fact_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] mism_cnt;
    logic [2:0] fail_vec;
    logic [4:0] first_fail;

    modport slave (
        input  start, f2_i, f2_min_i, f2_fact_i,
        output pat_o, busy, done, pass, mism_cnt, fail_vec, first_fail
    );

    modport master (
        output start, f2_i, f2_min_i, f2_fact_i,
        input  pat_o, busy, done, pass, mism_cnt, fail_vec, first_fail
    );
endinterface

// File: rtl/f2_equiv_sweeper.sv
// Purpose: sweeps all 32 {b,d,g,f,e} patterns into f2 and checks f2/f2_min/f2_fact against a golden model.
// Latency: SETTLE+2 cycles per pattern; done rises 32*(SETTLE+2)+1 cycles after the start edge.
// Backpressure: none; start is ignored while busy. F2_HALT_ON_FAIL_EN stops the sweep at the first mismatch.
module f2_equiv_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    f2_equiv_sweeper_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam bit         HAS_WAIT    = (SETTLE > 0);
    localparam logic [3:0] SETTLE_LAST = HAS_WAIT ? 4'(SETTLE - 1) : 4'd0;

    state_t     state, state_nxt;
    logic [4:0] idx;
    logic [3:0] wait_cnt;
    logic [4:0] pat_q;
    logic       busy_q, done_q, pass_q;
    logic [5:0] mism_q;
    logic [2:0] fail_q;
    logic [4:0] first_q;

    logic       golden;
    logic [2:0] fail_bits;
    logic       any_fail;
    logic       start_ok;

    // pat_q = {b,d,g,f,e}
    assign golden    = pat_q[2] & (pat_q[4] ? (pat_q[3] | pat_q[0]) : (~pat_q[3] | pat_q[1]));
    assign fail_bits = {bus.f2_i, bus.f2_min_i, bus.f2_fact_i} ^ {3{golden}};
    assign any_fail  = |fail_bits;
    assign start_ok  = bus.start & ((state == S_IDLE) | (state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                state_nxt = HAS_WAIT ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (wait_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
`ifdef F2_HALT_ON_FAIL_EN
                if (any_fail || idx == 5'd31) state_nxt = S_DONE;
                else                          state_nxt = S_DRIVE;
`else
                if (idx == 5'd31) state_nxt = S_DONE;
                else              state_nxt = S_DRIVE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 5'd0;
            wait_cnt <= 4'd0;
            pat_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mism_q   <= 6'd0;
            fail_q   <= 3'd0;
            first_q  <= 5'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        mism_q  <= 6'd0;
                        fail_q  <= 3'd0;
                        first_q <= 5'd0;
                        idx     <= 5'd0;
                    end else if (state == S_DONE) begin
                        done_q <= 1'b1;
                        pass_q <= (mism_q == 6'd0);
                    end
                end
                S_DRIVE: begin
                    pat_q    <= idx;
                    wait_cnt <= 4'd0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    // A pattern counts once no matter how many of its outputs disagree.
                    if (any_fail) begin
                        mism_q <= mism_q + 6'd1;
                        fail_q <= fail_q | fail_bits;
                        if (mism_q == 6'd0) first_q <= pat_q;
                    end
                    if (state_nxt == S_DONE) busy_q <= 1'b0;
                    else                     idx    <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pat_o      = pat_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.mism_cnt   = mism_q;
    assign bus.fail_vec   = fail_q;
    assign bus.first_fail = first_q;

endmodule

// File: tb/tb_f2_equiv_sweeper.sv
// Bench for f2_equiv_sweeper: emulates faulty/correct f2 blocks and predicts sweep results from the boolean spec.
module tb_f2_equiv_sweeper;

    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // 0 correct, 1 f2_min stuck 0, 2 f2_fact stuck 1, 3 random fault table, 4 f2 inverted
    int         mode = 0;
    logic [2:0] fmask [32];

    f2_equiv_sweeper_if bus ();

    f2_equiv_sweeper #(.SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit gold(input logic [4:0] p);
        bit b, d, g, f, e;
        {b, d, g, f, e} = p;
        return g && (b ? (d || e) : (!d || f));
    endfunction

    function automatic logic [2:0] resp_of(input logic [4:0] p, input int m, input logic [2:0] mask);
        logic [2:0] r;
        r = {3{gold(p)}};
        case (m)
            1: r[1] = 1'b0;
            2: r[0] = 1'b1;
            3: r = r ^ mask;
            4: r[2] = ~r[2];
            default: ;
        endcase
        return r;
    endfunction

    logic [2:0] resp;
    always_comb begin
        resp          = resp_of(bus.pat_o, mode, fmask[bus.pat_o]);
        bus.f2_i      = resp[2];
        bus.f2_min_i  = resp[1];
        bus.f2_fact_i = resp[0];
    end

    // Expected {pass, mism_cnt, fail_vec, first_fail}, cycles to done, and final pat_o.
    task automatic model(output logic [14:0] exp_res, output int exp_cyc, output logic [4:0] exp_pat);
        int         cnt;
        int         npat;
        logic [2:0] fv;
        logic [4:0] ff;
        logic [2:0] fb;
        cnt = 0; npat = 32; fv = 3'd0; ff = 5'd0;
        for (int p = 0; p < 32; p++) begin
            fb = resp_of(5'(p), mode, fmask[p]) ^ {3{gold(5'(p))}};
            if (fb != 3'd0) begin
                if (cnt == 0) ff = 5'(p);
                cnt++;
                fv = fv | fb;
`ifdef F2_HALT_ON_FAIL_EN
                npat = p + 1;
                break;
`endif
            end
        end
        exp_res = {(cnt == 0), 6'(cnt), fv, ff};
        exp_cyc = npat * (SETTLE + 2) + 1;
        exp_pat = 5'(npat - 1);
    endtask

    // Pulses start, then counts cycles until done; optional extra start pulse and mid-sweep reset.
    task automatic run_sweep(input int pulse_at, input int rst_at,
                             output int cyc, output int busy_fall, output logic done0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        done0 = bus.done;
        busy_fall = bus.busy ? -1 : 0;
        while (!bus.done && cyc < 4000) begin
            if (cyc == pulse_at) begin
                @(negedge clk);
                bus.start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
            if (!bus.busy && busy_fall < 0) busy_fall = cyc;
            if (cyc == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                break;
            end
        end
    endtask

    function automatic logic [14:0] results();
        return {bus.pass, bus.mism_cnt, bus.fail_vec, bus.first_fail};
    endfunction

    task automatic test_reset();
        logic [21:0] obs;
        rst_n = 1'b0;
        bus.start = 1'b0;
        #23;
        obs = {bus.busy, bus.done, bus.pass, bus.mism_cnt, bus.fail_vec, bus.first_fail, bus.pat_o};
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL reset_values got %h want 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_fault_models();
        int         modes [4] = '{0, 1, 2, 4};
        logic [14:0] er;
        int         ec, cyc, bf;
        logic [4:0] ep;
        logic       d0;
        for (int i = 0; i < 4; i++) begin
            mode = modes[i];
            model(er, ec, ep);
            run_sweep(-1, -1, cyc, bf, d0);
            checks++;
            if (cyc !== ec) begin
                errors++;
                $display("FAIL latency_mode%0d got %0d want %0d", mode, cyc, ec);
            end
            checks++;
            if (results() !== er) begin
                errors++;
                $display("FAIL results_mode%0d got %h want %h", mode, results(), er);
            end
            checks++;
            if (bus.pat_o !== ep) begin
                errors++;
                $display("FAIL pat_hold_mode%0d got %0d want %0d", mode, bus.pat_o, ep);
            end
            checks++;
            if (bf !== ec - 1) begin
                errors++;
                $display("FAIL busy_fall_mode%0d got %0d want %0d", mode, bf, ec - 1);
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] er;
        int         ec, cyc, bf;
        logic [4:0] ep;
        logic       d0;
        mode = 3;
        for (int it = 0; it < 6; it++) begin
            for (int p = 0; p < 32; p++)
                fmask[p] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            model(er, ec, ep);
            run_sweep(-1, -1, cyc, bf, d0);
            checks++;
            if (cyc !== ec || bf !== ec - 1) begin
                errors++;
                $display("FAIL rand%0d_timing done=%0d busy_fall=%0d want %0d %0d", it, cyc, bf, ec, ec - 1);
            end
            checks++;
            if (results() !== er || bus.pat_o !== ep) begin
                errors++;
                $display("FAIL rand%0d_results got %h pat %0d want %h pat %0d", it, results(), bus.pat_o, er, ep);
            end
        end
        for (int p = 0; p < 32; p++) fmask[p] = 3'd0;
    endtask

    task automatic test_restart_ignored();
        logic [14:0] er;
        int         ec, cyc, bf;
        logic [4:0] ep;
        logic       d0;
        mode = 1;
        model(er, ec, ep);
        run_sweep(10 * (SETTLE + 2) + 1, -1, cyc, bf, d0);
        checks++;
        if (cyc !== ec) begin
            errors++;
            $display("FAIL restart_latency got %0d want %0d", cyc, ec);
        end
        checks++;
        if (results() !== er) begin
            errors++;
            $display("FAIL restart_results got %h want %h", results(), er);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] er;
        int         ec, cyc, bf;
        logic [4:0] ep;
        logic       d0;
        logic [21:0] obs;
        mode = 2;
        run_sweep(-1, 17 * (SETTLE + 2) + 2, cyc, bf, d0);
        obs = {bus.busy, bus.done, bus.pass, bus.mism_cnt, bus.fail_vec, bus.first_fail, bus.pat_o};
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL abort_values got %h want 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        model(er, ec, ep);
        run_sweep(-1, -1, cyc, bf, d0);
        checks++;
        if (cyc !== ec || results() !== er) begin
            errors++;
            $display("FAIL after_abort got cyc %0d res %h want cyc %0d res %h", cyc, results(), ec, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] er;
        int         ec, cyc, bf;
        logic [4:0] ep;
        logic       d0;
        mode = 2;
        run_sweep(-1, -1, cyc, bf, d0);
        mode = 0;
        model(er, ec, ep);
        run_sweep(-1, -1, cyc, bf, d0);
        checks++;
        if (d0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_clear got %b want 0", d0);
        end
        checks++;
        if (cyc !== ec || results() !== er) begin
            errors++;
            $display("FAIL b2b_results got cyc %0d res %h want cyc %0d res %h", cyc, results(), ec, er);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int p = 0; p < 32; p++) fmask[p] = 3'd0;
        test_reset();
        test_fault_models();
        test_random();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
